// File: rtl/booth_multiplier_pkg.sv
// Shared definitions for the calculator multiply/divide datapaths.
//   state_t   : sequencer states used by the iterative datapaths
//   CALC_W    : default calculator operand width, shared with the divider
//   ERR_CODE  : error/undefined code driven on the result bus
package booth_multiplier_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int CALC_W = 4;

    localparam logic [7:0] ERR_CODE = 8'hFF;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration, purely combinational.
// Ports:
//   a, q      : accumulator and multiplier registers (WIDTH bits each)
//   q_1       : Booth guard bit
//   m         : multiplicand
//   a_next,
//   q_next,
//   q_1_next  : {A,Q,q_1} after the add/subtract and the arithmetic shift right
module booth_step
    import booth_multiplier_pkg::*;
#(
    parameter int WIDTH = CALC_W + 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] q,
    input  logic             q_1,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] a_next,
    output logic [WIDTH-1:0] q_next,
    output logic             q_1_next
);

    logic [WIDTH-1:0] sum;

    // Recode the pair {Q[0], q_1}: 01 ends a run of ones (add),
    // 10 starts one (subtract), 00/11 leave A alone.
    always_comb begin
        sum = a;
        case ({q[0], q_1})
            2'b01:   sum = a + m;
            2'b10:   sum = a - m;
            default: sum = a;
        endcase
    end

    // Arithmetic shift of {A,Q,q_1}: A's sign bit is replicated.
    assign a_next   = {sum[WIDTH-1], sum[WIDTH-1:1]};
    assign q_next   = {sum[0], q[WIDTH-1:1]};
    assign q_1_next = q[0];

endmodule

// File: rtl/booth_multiplier.sv
// Sequential radix-2 Booth multiplier, one Booth step per clock.
// Ports:
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   start        : request a multiply, only honoured while idle
//   multiplicand : operand M, captured on the accepting edge
//   multiplier   : operand Q, captured on the accepting edge
//   busy         : high while an operation is running
//   done         : one-cycle pulse when product has just been updated
//   product      : last completed result (2*WIDTH bits), held between results
// WIDTH must be at least 2.
module booth_multiplier
    import booth_multiplier_pkg::*;
#(
    parameter int WIDTH  = CALC_W,
    parameter int SIGNED = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    // One extra bit keeps unsigned operands with the top bit set from
    // being read as negative by the two's-complement Booth recoding.
    localparam int W1 = WIDTH + 1;
    localparam int CW = $clog2(W1 + 1);

    state_t          state;
    logic [W1-1:0]   m;
    logic [W1-1:0]   a;
    logic [W1-1:0]   q;
    logic            q_1;
    logic [CW-1:0]   cnt;

    logic [W1-1:0]   a_n;
    logic [W1-1:0]   q_n;
    logic            q_1_n;

    function automatic logic [W1-1:0] ext(input logic [WIDTH-1:0] x);
        return (SIGNED != 0) ? {x[WIDTH-1], x} : {1'b0, x};
    endfunction

    booth_step #(.WIDTH(W1)) u_step (
        .a        (a),
        .q        (q),
        .q_1      (q_1),
        .m        (m),
        .a_next   (a_n),
        .q_next   (q_n),
        .q_1_next (q_1_n)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            m       <= '0;
            a       <= '0;
            q       <= '0;
            q_1     <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        m     <= ext(multiplicand);
                        q     <= ext(multiplier);
                        a     <= '0;
                        q_1   <= 1'b0;
                        cnt   <= CW'(W1);
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a   <= a_n;
                    q   <= q_n;
                    q_1 <= q_1_n;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        // The exact product fits in 2*WIDTH bits, so the two
                        // top bits of A are redundant sign/zero copies.
                        product <= {a_n[WIDTH-2:0], q_n};
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier: one unsigned and one signed
// instance (WIDTH=4) driven from shared operand lines.
module tb_booth_multiplier;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       sel;
    logic [3:0] mcand;
    logic [3:0] mplier;

    logic       busy0, done0, busy1, done1;
    logic [7:0] prod0, prod1;
    logic       busy_s, done_s;
    logic [7:0] prod_s;

    int n_chk;
    int n_fail;

    logic start0, start1;
    assign start0 = start & ~sel;
    assign start1 = start & sel;
    assign busy_s = sel ? busy1 : busy0;
    assign done_s = sel ? done1 : done0;
    assign prod_s = sel ? prod1 : prod0;

    booth_multiplier #(.WIDTH(4), .SIGNED(0)) u_uns (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start0),
        .multiplicand (mcand),
        .multiplier   (mplier),
        .busy         (busy0),
        .done         (done0),
        .product      (prod0)
    );

    booth_multiplier #(.WIDTH(4), .SIGNED(1)) u_sgn (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start1),
        .multiplicand (mcand),
        .multiplier   (mplier),
        .busy         (busy1),
        .done         (done1),
        .product      (prod1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer multiply of the operand values, truncated.
    function automatic logic [7:0] ref_mul(input bit s, input logic [3:0] x, input logic [3:0] y);
        int xi, yi;
        xi = int'(x);
        yi = int'(y);
        if (s && xi >= 8) xi -= 16;
        if (s && yi >= 8) yi -= 16;
        return 8'(xi * yi);
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation, then verify accept, 5-cycle latency, busy
    // window, product and a single-cycle done pulse.
    task automatic do_op(input string tag, input bit s, input logic [3:0] x, input logic [3:0] y);
        logic [4:0] dv, bv;
        sel = s;
        @(negedge clk);
        mcand  = x;
        mplier = y;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check({tag, "_busy_accept"}, 16'(busy_s), 16'd1);
        dv = '0;
        bv = '0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            dv[i] = done_s;
            bv[i] = busy_s;
        end
        check({tag, "_done_latency"}, 16'(dv), 16'b10000);
        check({tag, "_busy_window"}, 16'(bv), 16'b01111);
        check({tag, "_product"}, 16'(prod_s), 16'(ref_mul(s, x, y)));
        @(posedge clk);
        #1;
        check({tag, "_done_width"}, 16'(done_s), 16'd0);
    endtask

    initial begin
        logic       any_done;
        logic [3:0] rx, ry;
        logic       rs;
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        sel    = 1'b0;
        mcand  = 4'd0;
        mplier = 4'd0;

        // Reset held while start toggles
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = ~start;
        end
        #1;
        check("rst_busy0", 16'(busy0), 16'd0);
        check("rst_done0", 16'(done0), 16'd0);
        check("rst_prod0", 16'(prod0), 16'd0);
        check("rst_busy1", 16'(busy1), 16'd0);
        check("rst_prod1", 16'(prod1), 16'd0);
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        any_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1 any_done = any_done | done0 | done1 | busy0 | busy1;
        end
        check("idle_no_done", 16'(any_done), 16'd0);

        // Directed cases
        do_op("u15x15", 1'b0, 4'd15, 4'd15);
        check("u15x15_const", 16'(prod0), 16'h00E1);
        do_op("s_m8x7", 1'b1, 4'h8, 4'h7);
        check("s_m8x7_const", 16'(prod1), 16'h00C8);
        do_op("s_m8xm8", 1'b1, 4'h8, 4'h8);
        check("s_m8xm8_const", 16'(prod1), 16'h0040);
        do_op("s_5xm3", 1'b1, 4'h5, 4'hD);
        check("s_5xm3_const", 16'(prod1), 16'h00F1);

        // Start while busy is ignored; start in the done cycle is accepted
        sel = 1'b0;
        @(negedge clk);
        mcand = 4'd3; mplier = 4'd5; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 2; i++) @(posedge clk);
        @(negedge clk);
        mcand = 4'd9; mplier = 4'd9; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 2; i++) @(posedge clk);
        #1;
        check("hs_done", 16'(done0), 16'd1);
        check("hs_ignored", 16'(prod0), 16'd15);
        mcand = 4'd6; mplier = 4'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("b2b_busy", 16'(busy0), 16'd1);
        for (int i = 0; i < 4; i++) @(posedge clk);
        #1;
        check("b2b_early", 16'(done0), 16'd0);
        @(posedge clk);
        #1;
        check("b2b_done", 16'(done0), 16'd1);
        check("b2b_prod", 16'(prod0), 16'd42);

        // Reset mid-operation
        @(negedge clk);
        mcand = 4'd11; mplier = 4'd11; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 2; i++) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 16'(busy0), 16'd0);
        check("mid_rst_prod", 16'(prod0), 16'd0);
        check("mid_rst_done", 16'(done0), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        any_done = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1 any_done = any_done | done0;
        end
        check("mid_rst_no_done", 16'(any_done), 16'd0);
        do_op("post_rst13x1", 1'b0, 4'd13, 4'd1);

        // Exhaustive, both modes
        for (int s = 0; s < 2; s++)
            for (int x = 0; x < 16; x++)
                for (int y = 0; y < 16; y++)
                    do_op(s != 0 ? "exh_s" : "exh_u", s[0], 4'(x), 4'(y));

        // Random order, random mode
        for (int k = 0; k < 24; k++) begin
            rs = 1'($urandom_range(0, 1));
            rx = 4'($urandom_range(0, 15));
            ry = 4'($urandom_range(0, 15));
            do_op("rnd", rs, rx, ry);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
